// File: rtl/lpf_obuf_reader_pkg.sv
// Shared definitions for the colour pipeline: RGB565 field layout, default
// raster geometry, and a helper that splits a 16-bit word into its fields.
package lpf_obuf_reader_pkg;

  localparam int unsigned PIX_W = 16;

  // RGB565 field positions
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  // Default raster geometry
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned X_W_DEF      = 10;
  localparam int unsigned Y_W_DEF      = 9;

  typedef struct packed {
    logic [R_MSB-R_LSB:0] r;
    logic [G_MSB-G_LSB:0] g;
    logic [B_MSB-B_LSB:0] b;
  } rgb565_t;

  function automatic rgb565_t rgb565_from_word(input logic [PIX_W-1:0] w);
    rgb565_t p;
    p.r = w[R_MSB:R_LSB];
    p.g = w[G_MSB:G_LSB];
    p.b = w[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/lpf_obuf_reader_skid_fifo2.sv
// Two-entry register FIFO used as the skid buffer behind the filter output
// FIFO. Entry 0 is always the head, so the output needs no read mux.
// Ports:
//   i_clk, i_rstn  clock, async active-low reset
//   i_clear        synchronous clear (wins over push/pop)
//   i_push, i_data write one pixel
//   i_pop          remove head (ignored when empty)
//   o_head         head pixel
//   o_occ          occupancy 0..2
module lpf_obuf_reader_skid_fifo2
  import lpf_obuf_reader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_pop,
  output logic [PIX_W-1:0] o_head,
  output logic [1:0]       o_occ
);

  logic [1:0] occ_q, occ_d;
  rgb565_t    ent0_q, ent0_d;
  rgb565_t    ent1_q, ent1_d;
  logic       do_pop;
  logic       do_push;
  logic [1:0] wr_idx;

  // Next-state: shift on pop, write into the first free slot after the pop.
  always_comb begin
    occ_d   = occ_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    do_pop  = i_pop && (occ_q != 2'd0);
    wr_idx  = occ_q - 2'(do_pop);
    do_push = i_push && (wr_idx != 2'd2);
    if (i_clear) begin
      occ_d = 2'd0;
    end else begin
      if (do_pop) begin
        ent0_d = ent1_q;
      end
      // A push into slot 0 overrides the shift, keeping FIFO order.
      if (do_push) begin
        if (wr_idx == 2'd0) begin
          ent0_d = rgb565_from_word(i_data);
        end else begin
          ent1_d = rgb565_from_word(i_data);
        end
      end
      occ_d = occ_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign o_head = ent0_q;
  assign o_occ  = occ_q;

endmodule

// File: rtl/lpf_obuf_reader.sv
// Drains the low-pass filter output FIFO and re-emits the pixels as a
// valid/ready stream tagged with raster coordinates and frame markers.
// The FIFO's one-cycle read latency is hidden by a 2-entry skid buffer.
// Ports:
//   i_clk, i_rstn        clock, async active-low reset
//   i_enable             permits new FIFO reads
//   i_flush              synchronous flush (shared with the filter)
//   o_obuf_rd            FIFO read strobe; data returns next cycle
//   i_obuf_data          RGB565 read data
//   i_obuf_empty         FIFO empty
//   o_valid/i_ready      output handshake
//   o_data, o_x, o_y     pixel and its coordinates
//   o_sof/o_eol/o_eof    frame markers, qualified by o_valid
//   o_frame_done         pulse the cycle after the eof handshake
module lpf_obuf_reader
  import lpf_obuf_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned Y_W      = Y_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_flush,
  output logic             o_obuf_rd,
  input  logic [PIX_W-1:0] i_obuf_data,
  input  logic             i_obuf_empty,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PIX_W-1:0] o_data,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_frame_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [1:0]       occ;
  logic [PIX_W-1:0] head;
  logic             inflight_q, inflight_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             frame_done_q, frame_done_d;
  logic             pop;
  logic             push;
  logic             rd;
  logic [2:0]       level;
  logic             at_sof, at_eol, at_eof;

  assign o_valid = (occ != 2'd0);
  assign pop     = o_valid & i_ready;

  // Entries held after this cycle's pop, counting the one in flight; a new
  // read is only allowed when its return is guaranteed a free slot.
  assign level = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign rd    = i_enable & ~i_flush & ~i_obuf_empty & (level < 3'd2);

  // A return landing in a flush cycle is dropped.
  assign push = inflight_q & ~i_flush;

  lpf_obuf_reader_skid_fifo2 u_skid (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clear (i_flush),
    .i_push  (push),
    .i_data  (i_obuf_data),
    .i_pop   (pop),
    .o_head  (head),
    .o_occ   (occ)
  );

  assign at_sof = (x_q == '0) && (y_q == '0);
  assign at_eol = (x_q == X_LAST);
  assign at_eof = at_eol && (y_q == Y_LAST);

  // Coordinate counters track the head pixel; flush has top priority.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    inflight_d   = rd;
    if (i_flush) begin
      x_d = '0;
      y_d = '0;
    end else if (pop) begin
      frame_done_d = at_eof;
      if (at_eol) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_obuf_rd    = rd;
  assign o_data       = head;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_sof        = o_valid & at_sof;
  assign o_eol        = o_valid & at_eol;
  assign o_eof        = o_valid & at_eof;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_lpf_obuf_reader.sv
// Scoreboard bench for lpf_obuf_reader: a source model of the filter FIFO
// pushes one expected pixel per read, a monitor pops and compares per output.
module tb_lpf_obuf_reader;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 2;

  typedef struct {
    logic [15:0] d;
    int unsigned x;
    int unsigned y;
    bit          sof;
    bit          eol;
    bit          eof;
    int unsigned rcyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rstn, i_enable, i_flush, i_ready, i_obuf_empty;
  logic [15:0]   i_obuf_data;
  logic          o_obuf_rd, o_valid, o_sof, o_eol, o_eof, o_frame_done;
  logic [15:0]   o_data;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] src_q[$];
  bit          pend = 1'b0;
  logic [15:0] pdata = '0;
  int unsigned idx = 0;
  bit          lat_chk = 1'b0;

  lpf_obuf_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)) dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_enable     (i_enable),
    .i_flush      (i_flush),
    .o_obuf_rd    (o_obuf_rd),
    .i_obuf_data  (i_obuf_data),
    .i_obuf_empty (i_obuf_empty),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_sof        (o_sof),
    .o_eol        (o_eol),
    .o_eof        (o_eof),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Source model: valid/read-rule checks from model occupancy, then serve reads.
  initial begin
    int   infl, occm;
    bit   vexp, hs, rexp;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_rstn) begin
        pend = 1'b0;
      end else begin
        infl = pend ? 1 : 0;
        occm = int'(exp_q.size()) - infl;
        vexp = (occm != 0);
        hs   = vexp && i_ready;
        check("o_valid", 32'(o_valid), 32'(vexp));
        rexp = i_enable && !i_flush && !i_obuf_empty && ((occm + infl - (hs ? 1 : 0)) < 2);
        check("o_obuf_rd", 32'(o_obuf_rd), 32'(rexp));
        if (i_flush) begin
          exp_q.delete();
          src_q.delete();
          idx  = 0;
          pend = 1'b0;
        end else if (o_obuf_rd && src_q.size() > 0) begin
          pdata  = src_q.pop_front();
          e.d    = pdata;
          e.x    = idx % H;
          e.y    = (idx / H) % V;
          e.sof  = (idx % (H * V)) == 0;
          e.eol  = e.x == H - 1;
          e.eof  = (idx % (H * V)) == H * V - 1;
          e.rcyc = cyc;
          exp_q.push_back(e);
          idx++;
          pend = 1'b1;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  // FIFO data returns the cycle after the read; garbage otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      i_obuf_data  = pend ? pdata : 16'($urandom);
      i_obuf_empty = (src_q.size() == 0);
    end
  end

  // Monitor: compare every presented pixel against the scoreboard head.
  initial begin
    bit   fd_exp, fd_next;
    exp_t e;
    fd_exp = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      fd_next = 1'b0;
      if (!i_rstn) begin
        fd_exp = 1'b0;
      end else begin
        check("o_frame_done", 32'(o_frame_done), 32'(fd_exp));
        if (!o_valid) begin
          check("markers_idle", 32'({o_sof, o_eol, o_eof}), 32'd0);
        end else if (!i_flush) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got pixel %h at (%0d,%0d) expected none", o_data, o_x, o_y);
          end else begin
            e = exp_q[0];
            check("o_data", 32'(o_data), 32'(e.d));
            check("o_x", 32'(o_x), e.x);
            check("o_y", 32'(o_y), e.y);
            check("o_sof", 32'(o_sof), 32'(e.sof));
            check("o_eol", 32'(o_eol), 32'(e.eol));
            check("o_eof", 32'(o_eof), 32'(e.eof));
            if (i_ready) begin
              void'(exp_q.pop_front());
              fd_next = e.eof;
              if (lat_chk) check("latency", cyc - e.rcyc, 32'd2);
            end
          end
        end
        fd_exp = fd_next;
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    i_flush  = 1'b0;
    i_enable = 1'b1;
    i_ready  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && src_q.size() == 0 && !pend) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_complete", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    bit seen;
    i_rstn = 1'b0; i_enable = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_obuf_data = '0; i_obuf_empty = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(o_obuf_rd), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_x", 32'(o_x), 0);
    check("rst_y", 32'(o_y), 0);
    check("rst_markers", 32'({o_sof, o_eol, o_eof}), 0);
    check("rst_frame_done", 32'(o_frame_done), 0);

    step();
    i_rstn = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_rd", 32'(o_obuf_rd), 0);
    check("idle_valid", 32'(o_valid), 0);

    // Two back-to-back frames at full rate
    step();
    lat_chk = 1'b1;
    for (int i = 1; i <= 16; i++) src_q.push_back(16'(i));
    drain();
    lat_chk = 1'b0;

    // Backpressure for 5 cycles mid-stream
    for (int i = 0; i < 12; i++) src_q.push_back(16'h0100 + 16'(i));
    repeat (4) step();
    i_ready = 1'b0;
    repeat (5) step();
    i_ready = 1'b1;
    drain();

    // Enable falls the cycle after a read
    for (int i = 0; i < 4; i++) src_q.push_back(16'h0200 + 16'(i));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_obuf_rd) begin seen = 1'b1; break; end
    end
    check("enable_rd_seen", 32'(seen), 1);
    step();
    i_enable = 1'b0;
    repeat (6) step();
    check("enable_drop_src_left", src_q.size(), 3);
    drain();

    // Flush while a pixel is buffered and another is in flight
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(16'h0300 + 16'(i));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (o_obuf_rd && exp_q.size() == 2) begin seen = 1'b1; break; end
    end
    check("flush_setup", 32'(seen), 1);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_valid_low", 32'(o_valid), 0);
    check("flush_xy", 32'({o_x, o_y}), 0);
    step();
    for (int i = 0; i < 4; i++) src_q.push_back(16'h0400 + 16'(i));
    drain();

    // Randomised traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      step();
      i_ready  = $urandom_range(0, 3) != 0;
      i_enable = $urandom_range(0, 7) != 0;
      i_flush  = $urandom_range(0, 39) == 0;
      if (!i_flush && $urandom_range(0, 2) != 0 && src_q.size() < 8)
        src_q.push_back(16'($urandom));
    end
    drain();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
